// File: rtl/hack_fetch_unit.sv
// Hack CPU instruction fetch sequencer: PC, ROM latency tracker, 2-entry output queue.
// Optional jump bounds fault enabled by defining FETCH_BOUNDS_CHECK_EN.
module hack_fetch_unit #(
    parameter int unsigned ROM_DEPTH   = 2048,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        CLK_100MHz,
    input  logic        RESET_N,
    output logic [15:0] pc,
    input  logic [15:0] rom_instruction,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        halt,
    output logic        fault
);

    typedef enum logic [1:0] {FETCH, HALTED, FAULTED} state_t;

    state_t                 state;
    logic                   epoch;
    logic [ROM_LATENCY-1:0] trk_vld;
    logic [ROM_LATENCY-1:0] trk_ep;
    logic [15:0]            trk_pc [ROM_LATENCY];
    logic [15:0]            s1_instr;
    logic [15:0]            s1_pc;
    logic                   s1_vld;

    logic [2:0]  infl_cnt;
    logic [2:0]  occ_after;
    logic        pop;
    logic        credit;
    logic        issue;
    logic        ret_vld;
    logic        push;
    logic        bad_tgt;
    logic [15:0] ret_pc;
    logic [15:0] pc_inc;
    logic [15:0] tgt_wrap;

    // Only current-epoch entries hold credit; stale ones are dropped on arrival.
    always_comb begin
        infl_cnt = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            if (trk_vld[i] && (trk_ep[i] == epoch))
                infl_cnt = infl_cnt + 3'd1;
        end
    end

    assign pop       = instr_valid & instr_ready;
    assign occ_after = {2'b00, instr_valid} + {2'b00, s1_vld} - {2'b00, pop};
    assign credit    = ({1'b0, occ_after} + {1'b0, infl_cnt}) < 4'(QUEUE_DEPTH);
    assign issue     = (state == FETCH) && !jump && credit;
    assign ret_vld   = trk_vld[ROM_LATENCY-1] && (trk_ep[ROM_LATENCY-1] == epoch);
    assign ret_pc    = trk_pc[ROM_LATENCY-1];
    assign push      = ret_vld && !jump && (state != FAULTED);
    assign pc_inc    = (pc == 16'(ROM_DEPTH - 1)) ? '0 : pc + 16'd1;
    assign tgt_wrap  = 16'(32'(jump_target) % ROM_DEPTH);

`ifdef FETCH_BOUNDS_CHECK_EN
    assign bad_tgt = 32'(jump_target) >= ROM_DEPTH;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N)
            fault <= 1'b0;
        else if (jump && bad_tgt && (state != FAULTED))
            fault <= 1'b1;
    end
`else
    assign bad_tgt = 1'b0;
    assign fault   = 1'b0;
`endif

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= FETCH;
            epoch       <= 1'b0;
            pc          <= '0;
            trk_vld     <= '0;
            trk_ep      <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++)
                trk_pc[i] <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            s1_instr    <= '0;
            s1_pc       <= '0;
            s1_vld      <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_ep[i]  <= trk_ep[i-1];
                trk_pc[i]  <= trk_pc[i-1];
            end
            trk_vld[0] <= issue;
            trk_ep[0]  <= epoch;
            trk_pc[0]  <= pc;

            if (issue)
                pc <= pc_inc;

            if (jump && (state != FAULTED)) begin
                epoch       <= ~epoch;
                instr_valid <= 1'b0;
                s1_vld      <= 1'b0;
                if (bad_tgt) begin
                    state <= FAULTED;
                end else begin
                    pc    <= tgt_wrap;
                    state <= halt ? HALTED : FETCH;
                end
            end else begin
                if (state != FAULTED)
                    state <= halt ? HALTED : FETCH;

                // Head slot feeds the outputs directly; s1 refills it on pop.
                if (instr_valid && !pop) begin
                    if (push) begin
                        s1_instr <= rom_instruction;
                        s1_pc    <= ret_pc;
                        s1_vld   <= 1'b1;
                    end
                end else if (s1_vld) begin
                    instr       <= s1_instr;
                    instr_pc    <= s1_pc;
                    instr_valid <= 1'b1;
                    s1_vld      <= push;
                    if (push) begin
                        s1_instr <= rom_instruction;
                        s1_pc    <= ret_pc;
                    end
                end else if (push) begin
                    instr       <= rom_instruction;
                    instr_pc    <= ret_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Randomized bench for hack_fetch_unit against a transaction-level queue model.
module tb_hack_fetch_unit;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned L     = 1;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        CLK_100MHz = 1'b0;
    logic        RESET_N    = 1'b0;
    logic [15:0] pc;
    logic [15:0] rom_instruction;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump        = 1'b0;
    logic [15:0] jump_target = '0;
    logic        halt        = 1'b0;
    logic        fault;

    hack_fetch_unit #(.ROM_DEPTH(DEPTH), .ROM_LATENCY(L), .QUEUE_DEPTH(2)) dut (
        .CLK_100MHz      (CLK_100MHz),
        .RESET_N         (RESET_N),
        .pc              (pc),
        .rom_instruction (rom_instruction),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .jump            (jump),
        .jump_target     (jump_target),
        .halt            (halt),
        .fault           (fault)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    // Synchronous ROM with L register stages on the address path.
    logic [15:0] rom_mem  [DEPTH];
    logic [15:0] rom_pipe [L];
    always @(posedge CLK_100MHz) begin
        rom_pipe[0] <= rom_mem[int'(pc) % DEPTH];
        for (int i = 1; i < L; i++)
            rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_instruction = rom_pipe[L-1];

    typedef struct { logic [15:0] addr; int due; bit stale; } fl_t;
    typedef struct { logic [15:0] d; logic [15:0] a; } oq_t;

    fl_t         fl_q[$];
    oq_t         oq[$];
    logic [15:0] m_pc, m_instr, m_instr_pc;
    bit          m_halted, m_faulted;
    int          now = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("pc", 32'(pc), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), (oq.size() > 0) ? 32'd1 : 32'd0);
        check("instr", 32'(instr), 32'(m_instr));
        check("instr_pc", 32'(instr_pc), 32'(m_instr_pc));
        check("fault", 32'(fault), 32'(m_faulted));
    endtask

    task automatic model_reset();
        fl_q.delete();
        oq.delete();
        m_pc = '0; m_instr = '0; m_instr_pc = '0;
        m_halted = 1'b0; m_faulted = 1'b0;
    endtask

    task automatic model_step(input bit j, input logic [15:0] tgt, input bit h, input bit r);
        int  cur = 0;
        int  popn;
        bit  iss;
        bit  acc = 1'b0;
        fl_t e;
        foreach (fl_q[i]) if (!fl_q[i].stale) cur++;
        popn = (oq.size() > 0 && r) ? 1 : 0;
        iss  = !m_halted && !m_faulted && !j && (oq.size() - popn + cur < 2);
        if (fl_q.size() > 0 && fl_q[0].due == now) begin
            e   = fl_q.pop_front();
            acc = !e.stale && !j && !m_faulted;
        end
        if (popn == 1) void'(oq.pop_front());
        if (j && !m_faulted) begin
            oq.delete();
            foreach (fl_q[i]) fl_q[i].stale = 1'b1;
            if (BC && int'(tgt) >= DEPTH) m_faulted = 1'b1;
            else m_pc = 16'(int'(tgt) % DEPTH);
        end else if (acc) begin
            oq.push_back('{d: rom_mem[int'(e.addr)], a: e.addr});
        end
        if (!m_faulted) m_halted = h;
        if (iss) begin
            fl_q.push_back('{addr: m_pc, due: now + L, stale: 1'b0});
            m_pc = 16'((int'(m_pc) + 1) % DEPTH);
        end
        if (oq.size() > 0) begin
            m_instr    = oq[0].d;
            m_instr_pc = oq[0].a;
        end
        now++;
    endtask

    task automatic cycle(input bit j, input logic [15:0] tgt, input bit h, input bit r);
        compare_outputs();
        jump = j; jump_target = tgt; halt = h; instr_ready = r;
        model_step(j, tgt, h, r);
        @(posedge CLK_100MHz);
        @(negedge CLK_100MHz);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        jump = 1'b0; halt = 1'b0; instr_ready = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge CLK_100MHz);
        @(negedge CLK_100MHz);
        RESET_N = 1'b1;
    endtask

    initial begin
        bit          j, h, r;
        logic [15:0] tgt;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0] = 16'h0011; rom_mem[1] = 16'h0022;
        rom_mem[2] = 16'h0033; rom_mem[3] = 16'h0044;
        @(negedge CLK_100MHz);
        do_reset();
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);

        // Backpressure from reset: two words queue, pc parks at 2.
        do_reset();
        repeat (12) cycle(1'b0, '0, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0100, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);

        cycle(1'b1, 16'd2047, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);

        repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

        cycle(1'b1, 16'h0200, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 16'h0300, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

        cycle(1'b1, 16'd2048, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0 || (m_faulted && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                j   = ($urandom_range(0, 19) == 0);
                tgt = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(2048, 65535))
                                                  : 16'($urandom_range(0, 2047));
                h   = ($urandom_range(0, 9) == 0);
                r   = ($urandom_range(0, 3) != 0);
                cycle(j, tgt, h, r);
            end
        end
        compare_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
